// File: rtl/nested_loop_pkg.sv
// Shared encodings and default widths for the nested-loop configuration
// controller and its register file.
package nested_loop_pkg;

  localparam int DEF_NUM_MAX_LOOPS     = 7;
  localparam int DEF_LOG_NUM_MAX_LOOPS = 3;
  localparam int DEF_BASE_WIDTH        = 32;
  localparam int DEF_NUM_ITER_WIDTH    = 32;
  localparam int DEF_DATA_WIDTH        = 32;
  localparam int DEF_MASK_CYCLES       = 3;

  // Command opcodes carried on cfg_op.
  typedef enum logic [1:0] {
    OP_SET_BASE   = 2'd0,
    OP_SET_ITER   = 2'd1,
    OP_SET_STRIDE = 2'd2,
    OP_START      = 2'd3
  } cfg_op_e;

  // Controller FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/nested_loop_cfg_regs.sv
// Loop configuration register file: one base register plus a stride and an
// iteration count per loop level, written by level index. Outputs are the
// registers themselves, flattened with level i at slice [i*W +: W].
module nested_loop_cfg_regs
  import nested_loop_pkg::*;
#(
  parameter int NUM_MAX_LOOPS     = DEF_NUM_MAX_LOOPS,
  parameter int LOG_NUM_MAX_LOOPS = DEF_LOG_NUM_MAX_LOOPS,
  parameter int BASE_WIDTH        = DEF_BASE_WIDTH,
  parameter int STRIDE_WIDTH      = BASE_WIDTH,
  parameter int NUM_ITER_WIDTH    = DEF_NUM_ITER_WIDTH,
  parameter int DATA_WIDTH        = DEF_DATA_WIDTH
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic                                    we_base_i,
  input  logic                                    we_iter_i,
  input  logic                                    we_stride_i,
  input  logic [LOG_NUM_MAX_LOOPS-1:0]            idx_i,
  input  logic [DATA_WIDTH-1:0]                   data_i,
  output logic [BASE_WIDTH-1:0]                   base_o,
  output logic [STRIDE_WIDTH*NUM_MAX_LOOPS-1:0]   stride_o,
  output logic [NUM_ITER_WIDTH*NUM_MAX_LOOPS-1:0] num_iter_o
);

  logic [BASE_WIDTH-1:0]     base_q;
  logic [STRIDE_WIDTH-1:0]   stride_q [NUM_MAX_LOOPS];
  logic [NUM_ITER_WIDTH-1:0] iter_q   [NUM_MAX_LOOPS];

  // Register writes; the caller only raises a level write enable for a legal
  // index, and the per-level compare keeps array indexing in range.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      base_q <= '0;
      for (int i = 0; i < NUM_MAX_LOOPS; i++) begin
        stride_q[i] <= '0;
        iter_q[i]   <= '0;
      end
    end else begin
      if (we_base_i) begin
        base_q <= data_i[BASE_WIDTH-1:0];
      end
      for (int i = 0; i < NUM_MAX_LOOPS; i++) begin
        if (we_stride_i && (idx_i == LOG_NUM_MAX_LOOPS'(i))) begin
          stride_q[i] <= data_i[STRIDE_WIDTH-1:0];
        end
        if (we_iter_i && (idx_i == LOG_NUM_MAX_LOOPS'(i))) begin
          iter_q[i] <= data_i[NUM_ITER_WIDTH-1:0];
        end
      end
    end
  end

  assign base_o = base_q;

  for (genvar g = 0; g < NUM_MAX_LOOPS; g++) begin : g_flat
    assign stride_o[g*STRIDE_WIDTH +: STRIDE_WIDTH]       = stride_q[g];
    assign num_iter_o[g*NUM_ITER_WIDTH +: NUM_ITER_WIDTH] = iter_q[g];
  end

endmodule

// File: rtl/nested_loop_cfg_ctrl.sv
// Programming-side controller for one nested-loop address generator.
// Collects configuration commands from the SIMD decoder, launches the
// generator on START, keeps it in loop mode until it reports done, then
// pulses done_pulse upstream.
//
// Command handshake: a command transfers on a rising edge where
// cfg_valid && cfg_ready are both high. cfg_ready is high only in IDLE;
// while it is low the upstream keeps cfg_valid, cfg_op, cfg_loop_idx and
// cfg_data stable, so a stalled command is taken in the first IDLE cycle.
module nested_loop_cfg_ctrl
  import nested_loop_pkg::*;
#(
  parameter int NUM_MAX_LOOPS     = DEF_NUM_MAX_LOOPS,
  parameter int LOG_NUM_MAX_LOOPS = DEF_LOG_NUM_MAX_LOOPS,
  parameter int BASE_WIDTH        = DEF_BASE_WIDTH,
  parameter int STRIDE_WIDTH      = BASE_WIDTH,
  parameter int NUM_ITER_WIDTH    = DEF_NUM_ITER_WIDTH,
  parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
  parameter int MASK_CYCLES       = DEF_MASK_CYCLES
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    cfg_valid,
  output logic                                    cfg_ready,
  input  logic [1:0]                              cfg_op,
  input  logic [LOG_NUM_MAX_LOOPS-1:0]            cfg_loop_idx,
  input  logic [DATA_WIDTH-1:0]                   cfg_data,
  output logic [BASE_WIDTH-1:0]                   base,
  output logic [STRIDE_WIDTH*NUM_MAX_LOOPS-1:0]   stride,
  output logic [NUM_ITER_WIDTH*NUM_MAX_LOOPS-1:0] num_iter,
  output logic                                    start_loop,
  output logic                                    in_nested_loop,
  input  logic                                    loop_done_in,
  output logic                                    busy,
  output logic                                    done_pulse,
  output logic                                    cfg_err,
  output state_e                                  dbg_state
);

  // Counter must be able to hold MASK_CYCLES itself (saturating value).
  localparam int MASK_W = (MASK_CYCLES < 1) ? 1 : $clog2(MASK_CYCLES + 1);

  state_e            state_q, state_d;
  logic [MASK_W-1:0] mask_cnt_q, mask_cnt_d;
  logic              cfg_ready_q, start_loop_q, in_loop_q, busy_q;
  logic              done_pulse_q, cfg_err_q, cfg_err_d;

  cfg_op_e           cmd_op;
  logic              cmd_acc;
  logic              idx_ok;
  logic              mask_open;
  logic              we_base, we_iter, we_stride;
  logic [31:0]       idx_ext;

  assign cmd_op  = cfg_op_e'(cfg_op);
  assign cmd_acc = cfg_valid && cfg_ready_q;
  assign idx_ext = 32'(cfg_loop_idx);
  assign idx_ok  = idx_ext < 32'(NUM_MAX_LOOPS);

  // The done input from the generator may still be high from the previous
  // run, so it is only trusted once the counter has saturated.
  assign mask_open = (mask_cnt_q == MASK_W'(MASK_CYCLES));

  // Decode accepted commands into register-file write strobes and the error pulse.
  always_comb begin
    we_base   = 1'b0;
    we_iter   = 1'b0;
    we_stride = 1'b0;
    cfg_err_d = 1'b0;
    if (cmd_acc) begin
      case (cmd_op)
        OP_SET_BASE:   we_base = 1'b1;
        OP_SET_ITER:   begin
          we_iter   = idx_ok;
          cfg_err_d = !idx_ok;
        end
        OP_SET_STRIDE: begin
          we_stride = idx_ok;
          cfg_err_d = !idx_ok;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic and RUN-phase mask counter.
  always_comb begin
    state_d    = state_q;
    mask_cnt_d = mask_cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_acc && (cmd_op == OP_START)) begin
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        state_d    = RUN;
        mask_cnt_d = '0;
      end
      RUN: begin
        if (mask_open) begin
          if (loop_done_in) begin
            state_d = DONE;
          end
        end else begin
          mask_cnt_d = mask_cnt_q + MASK_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mask_cnt_q   <= '0;
      cfg_ready_q  <= 1'b1;
      start_loop_q <= 1'b0;
      in_loop_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_pulse_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_cnt_q   <= mask_cnt_d;
      cfg_ready_q  <= (state_d == IDLE);
      start_loop_q <= (state_d == LAUNCH);
      in_loop_q    <= (state_d == RUN);
      busy_q       <= (state_d != IDLE);
      done_pulse_q <= (state_d == DONE);
      cfg_err_q    <= cfg_err_d;
    end
  end

  nested_loop_cfg_regs #(
    .NUM_MAX_LOOPS     (NUM_MAX_LOOPS),
    .LOG_NUM_MAX_LOOPS (LOG_NUM_MAX_LOOPS),
    .BASE_WIDTH        (BASE_WIDTH),
    .STRIDE_WIDTH      (STRIDE_WIDTH),
    .NUM_ITER_WIDTH    (NUM_ITER_WIDTH),
    .DATA_WIDTH        (DATA_WIDTH)
  ) u_regs (
    .clk_i       (clk),
    .reset_i     (reset),
    .we_base_i   (we_base),
    .we_iter_i   (we_iter),
    .we_stride_i (we_stride),
    .idx_i       (cfg_loop_idx),
    .data_i      (cfg_data),
    .base_o      (base),
    .stride_o    (stride),
    .num_iter_o  (num_iter)
  );

  assign cfg_ready      = cfg_ready_q;
  assign start_loop     = start_loop_q;
  assign in_nested_loop = in_loop_q;
  assign busy           = busy_q;
  assign done_pulse     = done_pulse_q;
  assign cfg_err        = cfg_err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_nested_loop_cfg_ctrl.sv
// Bench for nested_loop_cfg_ctrl: table of configuration commands with
// hand-computed expectations, then hand-written launch/run sequences.
module tb_nested_loop_cfg_ctrl;
  import nested_loop_pkg::*;

  localparam int NL = 7;
  localparam int LW = 3;
  localparam int BW = 32;
  localparam int SW = 32;
  localparam int IW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic [1:0]      cfg_op = 2'd0;
  logic [LW-1:0]   cfg_loop_idx = '0;
  logic [DW-1:0]   cfg_data = '0;
  logic [BW-1:0]   base;
  logic [SW*NL-1:0] stride;
  logic [IW*NL-1:0] num_iter;
  logic            start_loop;
  logic            in_nested_loop;
  logic            loop_done_in = 1'b0;
  logic            busy;
  logic            done_pulse;
  logic            cfg_err;
  state_e          dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];

  logic [BW-1:0] m_base;
  logic [SW-1:0] m_stride [NL];
  logic [IW-1:0] m_iter   [NL];

  typedef struct {
    logic [1:0]    op;
    logic [LW-1:0] idx;
    logic [DW-1:0] data;
    logic          exp_err;
  } vec_t;

  vec_t vecs[10];

  nested_loop_cfg_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_op         (cfg_op),
    .cfg_loop_idx   (cfg_loop_idx),
    .cfg_data       (cfg_data),
    .base           (base),
    .stride         (stride),
    .num_iter       (num_iter),
    .start_loop     (start_loop),
    .in_nested_loop (in_nested_loop),
    .loop_done_in   (loop_done_in),
    .busy           (busy),
    .done_pulse     (done_pulse),
    .cfg_err        (cfg_err),
    .dbg_state      (dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse monitor: each start_loop must land in the cycle queued by the driver.
  always @(negedge clk) begin
    if (!reset) begin
      if (done_pulse) done_cnt++;
      if (start_loop) begin
        start_cnt++;
        if (exp_q.size() == 0) begin
          check("start_unexpected", 1'b1, 1'b0);
        end else begin
          check("start_cycle", 32'(cyc), exp_q.pop_front());
        end
      end
    end
  end

  function automatic logic [SW*NL-1:0] pack_stride();
    logic [SW*NL-1:0] v;
    for (int i = 0; i < NL; i++) v[i*SW +: SW] = m_stride[i];
    return v;
  endfunction

  function automatic logic [IW*NL-1:0] pack_iter();
    logic [IW*NL-1:0] v;
    for (int i = 0; i < NL; i++) v[i*IW +: IW] = m_iter[i];
    return v;
  endfunction

  // Driver: offer one command in IDLE; it is taken on the next rising edge.
  task automatic cfg_write(input logic [1:0] op, input logic [LW-1:0] idx, input logic [DW-1:0] data);
    @(negedge clk);
    cfg_valid    = 1'b1;
    cfg_op       = op;
    cfg_loop_idx = idx;
    cfg_data     = data;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic send_start();
    cfg_write(OP_START, '0, '0);
    exp_q.push_back(32'(cyc));
  endtask

  initial begin
    int got_k;

    vecs[0] = '{op: OP_SET_BASE,   idx: 3'd0, data: 32'h0000_0100, exp_err: 1'b0};
    vecs[1] = '{op: OP_SET_ITER,   idx: 3'd5, data: 32'd2,         exp_err: 1'b0};
    vecs[2] = '{op: OP_SET_ITER,   idx: 3'd6, data: 32'd3,         exp_err: 1'b0};
    vecs[3] = '{op: OP_SET_STRIDE, idx: 3'd5, data: 32'h0000_0040, exp_err: 1'b0};
    vecs[4] = '{op: OP_SET_STRIDE, idx: 3'd7, data: 32'h0000_dead, exp_err: 1'b1};
    vecs[5] = '{op: OP_SET_STRIDE, idx: 3'd6, data: 32'h0000_0004, exp_err: 1'b0};
    vecs[6] = '{op: OP_SET_ITER,   idx: 3'd7, data: 32'h0000_0055, exp_err: 1'b1};
    vecs[7] = '{op: OP_SET_ITER,   idx: 3'd0, data: 32'd0,         exp_err: 1'b0};
    vecs[8] = '{op: OP_SET_ITER,   idx: 3'd0, data: 32'd9,         exp_err: 1'b0};
    vecs[9] = '{op: OP_SET_STRIDE, idx: 3'd3, data: 32'hffff_ffff, exp_err: 1'b0};

    m_base = '0;
    for (int i = 0; i < NL; i++) begin
      m_stride[i] = '0;
      m_iter[i]   = '0;
    end

    // Reset state.
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_base", base, '0);
    check("rst_stride", stride, '0);
    check("rst_num_iter", num_iter, '0);
    check("rst_start_loop", start_loop, 1'b0);
    check("rst_in_loop", in_nested_loop, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done_pulse", done_pulse, 1'b0);
    check("rst_cfg_err", cfg_err, 1'b0);
    check("rst_cfg_ready", cfg_ready, 1'b1);

    // Configuration table.
    for (int v = 0; v < 10; v++) begin
      cfg_write(vecs[v].op, vecs[v].idx, vecs[v].data);
      if (vecs[v].op == OP_SET_BASE) m_base = vecs[v].data;
      if (vecs[v].idx < LW'(NL)) begin
        if (vecs[v].op == OP_SET_ITER)   m_iter[vecs[v].idx]   = vecs[v].data;
        if (vecs[v].op == OP_SET_STRIDE) m_stride[vecs[v].idx] = vecs[v].data;
      end
      check($sformatf("vec%0d_base", v), base, m_base);
      check($sformatf("vec%0d_stride", v), stride, pack_stride());
      check($sformatf("vec%0d_num_iter", v), num_iter, pack_iter());
      check($sformatf("vec%0d_cfg_err", v), cfg_err, vecs[v].exp_err);
      check($sformatf("vec%0d_cfg_ready", v), cfg_ready, 1'b1);
    end

    // Documented bit offsets, hand values.
    check("ofs_base", base, 32'h100);
    check("ofs_stride5", stride[5*SW +: SW], 32'h40);
    check("ofs_stride6", stride[6*SW +: SW], 32'h4);
    check("ofs_iter5", num_iter[5*IW +: IW], 32'd2);
    check("ofs_iter6", num_iter[6*IW +: IW], 32'd3);
    check("ofs_iter0_last", num_iter[0 +: IW], 32'd9);

    // Run 1: launch, hold in loop, then done.
    send_start();
    check("r1_start", start_loop, 1'b1);
    check("r1_in_loop_launch", in_nested_loop, 1'b0);
    check("r1_ready_launch", cfg_ready, 1'b0);
    check("r1_busy_launch", busy, 1'b1);
    @(posedge clk);
    #1;
    check("r1_start_drop", start_loop, 1'b0);
    check("r1_in_loop", in_nested_loop, 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      check("r1_in_loop_hold", in_nested_loop, 1'b1);
    end
    @(negedge clk);
    loop_done_in = 1'b1;
    @(posedge clk);
    #1;
    check("r1_done_pulse", done_pulse, 1'b1);
    check("r1_in_loop_off", in_nested_loop, 1'b0);
    @(negedge clk);
    loop_done_in = 1'b0;
    @(posedge clk);
    #1;
    check("r1_done_drop", done_pulse, 1'b0);
    check("r1_ready_back", cfg_ready, 1'b1);
    check("r1_busy_off", busy, 1'b0);
    check("r1_base_kept", base, m_base);
    check("r1_start_cnt", start_cnt, 1);

    // Run 2: done held high from the first RUN cycle is masked.
    send_start();
    @(negedge clk);
    loop_done_in = 1'b1;
    got_k = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done_pulse) begin
        got_k = k;
        break;
      end
      check("r2_in_loop_masked", in_nested_loop, 1'b1);
    end
    check("r2_done_edge", got_k, 5);
    @(negedge clk);
    loop_done_in = 1'b0;
    @(posedge clk);
    #1;
    check("r2_ready_back", cfg_ready, 1'b1);

    // Run 3: SET_ITER held during RUN stalls until IDLE.
    send_start();
    @(negedge clk);
    cfg_valid    = 1'b1;
    cfg_op       = OP_SET_ITER;
    cfg_loop_idx = 3'd5;
    cfg_data     = 32'h77;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      check("r3_ready_low", cfg_ready, 1'b0);
      check("r3_iter5_old", num_iter[5*IW +: IW], 32'd2);
    end
    @(negedge clk);
    loop_done_in = 1'b1;
    @(posedge clk);
    #1;
    check("r3_done_pulse", done_pulse, 1'b1);
    check("r3_iter5_done", num_iter[5*IW +: IW], 32'd2);
    @(negedge clk);
    loop_done_in = 1'b0;
    @(posedge clk);
    #1;
    check("r3_ready_idle", cfg_ready, 1'b1);
    check("r3_iter5_idle", num_iter[5*IW +: IW], 32'd2);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    m_iter[5] = 32'h77;
    check("r3_iter5_new", num_iter[5*IW +: IW], 32'h77);
    check("r3_num_iter_all", num_iter, pack_iter());
    check("r3_done_cnt", done_cnt, 3);

    // Run 4: reset while in RUN.
    send_start();
    @(posedge clk);
    #1;
    check("r4_in_loop", in_nested_loop, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    loop_done_in = 1'b1;
    @(posedge clk);
    #1;
    check("r4_in_loop_off", in_nested_loop, 1'b0);
    check("r4_done_pulse", done_pulse, 1'b0);
    check("r4_base", base, '0);
    check("r4_stride", stride, '0);
    check("r4_num_iter", num_iter, '0);
    check("r4_ready", cfg_ready, 1'b1);
    check("r4_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    loop_done_in = 1'b0;
    check("r4_no_done", done_cnt, 3);
    check("r4_idle_in_loop", in_nested_loop, 1'b0);
    check("r4_idle_busy", busy, 1'b0);

    check("start_all_seen", exp_q.size(), 0);
    check("start_total", start_cnt, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
